// File: rtl/multicycle_control_unit_pkg.sv
// ============================================================================
//  Module   : cu_pkg
//  Purpose  : Shared types and opcode-class constants for the multi-cycle
//             LEGv8 control unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  localparam int OPC_W = 11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  // Opcode classes as (mask, match) pairs; masked-out bits are don't-care.
  localparam logic [OPC_W-1:0] R_MASK     = 11'b100_1111_0111;
  localparam logic [OPC_W-1:0] R_MATCH    = 11'b100_0101_0000;
  localparam logic [OPC_W-1:0] LDUR_MASK  = 11'b111_1111_1111;
  localparam logic [OPC_W-1:0] LDUR_MATCH = 11'b111_1100_0010;
  localparam logic [OPC_W-1:0] STUR_MASK  = 11'b111_1111_1111;
  localparam logic [OPC_W-1:0] STUR_MATCH = 11'b111_1100_0000;
  localparam logic [OPC_W-1:0] CBZ_MASK   = 11'b111_1111_1000;
  localparam logic [OPC_W-1:0] CBZ_MATCH  = 11'b101_1010_0000;
  localparam logic [OPC_W-1:0] B_MASK     = 11'b111_1110_0000;
  localparam logic [OPC_W-1:0] B_MATCH    = 11'b000_1010_0000;
  localparam logic [OPC_W-1:0] IMM_MASK   = 11'b101_1111_1100;
  localparam logic [OPC_W-1:0] IMM_MATCH  = 11'b100_1000_1000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASS  = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  typedef struct packed {
    logic r;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic imm;
  } opc_class_t;

  function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                     input logic [OPC_W-1:0] mask,
                                     input logic [OPC_W-1:0] match);
    return (opc & mask) == match;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// ============================================================================
//  Module   : opcode_classifier
//  Purpose  : Combinational opcode -> one-hot instruction class.
//             CU_IMM_EN adds the ADDI/SUBI immediate class.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_classifier
  import cu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output opc_class_t       cls
);

  assign cls.r    = opc_match(opcode, R_MASK,    R_MATCH);
  assign cls.ldur = opc_match(opcode, LDUR_MASK, LDUR_MATCH);
  assign cls.stur = opc_match(opcode, STUR_MASK, STUR_MATCH);
  assign cls.cbz  = opc_match(opcode, CBZ_MASK,  CBZ_MATCH);
  assign cls.b    = opc_match(opcode, B_MASK,    B_MATCH);

`ifdef CU_IMM_EN
  assign cls.imm  = opc_match(opcode, IMM_MASK,  IMM_MATCH);
`else
  assign cls.imm  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle LEGv8
//             datapath with memory timeout. Optional macro: CU_IMM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                reg2loc,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                uncond_branch,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                ir_write,
  output logic                pc_write,
  output logic                instr_done,
  output logic                illegal,
  output logic                bus_error
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  opc_class_t          cls;
  logic                fetch_done, mem_done, timeout, retire_evt, exec_n;

  logic mem_req_q, mem_req_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic reg2loc_q, reg2loc_d, alu_src_q, alu_src_d, mem_to_reg_q, mem_to_reg_d;
  logic reg_write_q, reg_write_d, uncond_q, uncond_d, cbz_exec_q, cbz_exec_d;
  logic instr_done_q, instr_done_d, illegal_q, illegal_d, bus_error_q, bus_error_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;

  // Classifies the live opcode while in DECODE, the latched one afterwards.
  opcode_classifier u_classifier (
    .opcode (opc_d),
    .cls    (cls)
  );

  always_comb begin
    opc_d       = (state_q == DECODE) ? opcode : opc_q;
    fetch_done  = (state_q == FETCH) && mem_req_q && mem_ready;
    mem_done    = (state_q == MEM) && mem_req_q && mem_ready;
    timeout     = mem_req_q && !mem_ready && (cnt_q == CNT_LIMIT);
    state_d     = state_q;
    retire_evt  = 1'b0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q | timeout;

    case (state_q)
      FETCH:  if (fetch_done) state_d = DECODE;
      DECODE: begin
        if (cls == '0) begin
          illegal_d  = 1'b1;
          retire_evt = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls.ldur || cls.stur)   state_d = MEM;
        else if (cls.r || cls.imm)  state_d = WB;
        else                        state_d = FETCH;
      end
      MEM: begin
        if (mem_done) begin
          if (cls.ldur) begin
            state_d = WB;
          end else begin
            state_d    = FETCH;
            retire_evt = 1'b1;
          end
        end else if (timeout) begin
          state_d = FETCH;
        end
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase

    // A timed-out FETCH re-enters FETCH, so it also restarts the count.
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout)
      cnt_d = '0;
    else if (mem_req_q && !mem_ready && (cnt_q < CNT_LIMIT))
      cnt_d = cnt_q + CNT_W'(1);

    // Output registers hold the Moore decode of the state being entered.
    exec_n       = (state_d == EXEC);
    mem_req_d    = ((state_d == FETCH) && !timeout) || (state_d == MEM);
    mem_read_d   = mem_req_d && ((state_d == FETCH) || cls.ldur);
    mem_write_d  = (state_d == MEM) && cls.stur;
    alu_src_d    = exec_n && (cls.ldur || cls.stur || cls.imm);
    reg2loc_d    = exec_n && (cls.stur || cls.cbz);
    cbz_exec_d   = exec_n && cls.cbz;
    uncond_d     = exec_n && cls.b;
    reg_write_d  = (state_d == WB);
    mem_to_reg_d = (state_d == WB) && cls.ldur;
    instr_done_d = (state_d == WB) || (exec_n && (cls.cbz || cls.b)) || retire_evt;
    if (exec_n && (cls.r || cls.imm))
      alu_op_d = ALUOP_W'(ALU_OP_RTYPE);
    else if (exec_n && cls.cbz)
      alu_op_d = ALUOP_W'(ALU_OP_PASS);
    else
      alu_op_d = ALUOP_W'(ALU_OP_ADD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      opc_q        <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b1;
      mem_read_q   <= 1'b1;
      mem_write_q  <= 1'b0;
      reg2loc_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      uncond_q     <= 1'b0;
      cbz_exec_q   <= 1'b0;
      alu_op_q     <= '0;
      instr_done_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg2loc_q    <= reg2loc_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      uncond_q     <= uncond_d;
      cbz_exec_q   <= cbz_exec_d;
      alu_op_q     <= alu_op_d;
      instr_done_q <= instr_done_d;
      illegal_q    <= illegal_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // The IR load and the CBZ decision depend on same-cycle inputs.
  assign ir_write      = fetch_done;
  assign branch        = cbz_exec_q & zero;
  assign pc_write      = fetch_done | (cbz_exec_q & zero) | uncond_q;
  assign mem_req       = mem_req_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign reg2loc       = reg2loc_q;
  assign alu_src       = alu_src_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign reg_write     = reg_write_q;
  assign uncond_branch = uncond_q;
  assign alu_op        = alu_op_q;
  assign instr_done    = instr_done_q;
  assign illegal       = illegal_q;
  assign bus_error     = bus_error_q;

endmodule

`default_nettype wire
